// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encoding,
// read-response owner tags and the starvation counter width.
// Optional statistics block in the top is enabled with DMEM_ARB_STATS_EN.
package dmem_port_arbiter_pkg;

  // Mode sequencing between normal run and a UART programming session.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PROG  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // Owner of the read response returning on the cycle after a granted read.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } own_t;

  // Starvation counter width; covers STARVE_MAX up to 255.
  localparam int STARVE_W = 8;

  // Width of each saturating statistics counter.
  localparam int STAT_W = 16;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating up-counter with synchronous clear and an at-limit flag.
// Used as the debug-port starvation counter and for the statistics counters.
module dmem_arb_starve_ctr #(
  parameter int            W   = 8,
  parameter logic [W-1:0]  MAX = '1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  // Clear wins over increment; the count holds once it reaches MAX.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == MAX);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbiter for the single synchronous-read data-memory port shared by the UART
// programmer, the CPU load/store path and the debug readback port.
// Fixed priority forced-debug > CPU > debug, with a starvation guard that
// forces a debug grant after STARVE_MAX cycles of waiting.
// Handshake: a request is accepted in the cycle the memory port is driven for
// it (combinational grant); a granted read returns one cycle later, flagged by
// exactly one of cpu_rvalid_o / dbg_rvalid_o for that single cycle.
// Define DMEM_ARB_STATS_EN to add grant/stall counters on stats_o.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              upg_rst_i,
  input  logic              upg_done_i,
  input  logic              upg_we_i,
  input  logic [ADDR_W-1:0] upg_addr_i,
  input  logic [DATA_W-1:0] upg_wdata_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic              dbg_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              cpu_rvalid_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              prog_busy_o,
`ifdef DMEM_ARB_STATS_EN
  output logic [47:0]       stats_o,
`endif
  output arb_state_t        state_o,
  output logic [STARVE_W-1:0] starve_cnt_o
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_t state_q;
  logic       upg_rst_q;
  own_t       tag_q;
  logic       starve_at_max;
  logic       forced_dbg;
  logic       cpu_gnt;
  logic       enter_prog;
  logic       leave_prog;

  // Programming starts on a falling edge of upg_rst_i seen while running,
  // and ends on upg_done_i or a rising edge of upg_rst_i.
  assign enter_prog = (state_q == RUN) && upg_rst_q && !upg_rst_i;
  assign leave_prog = upg_done_i || (upg_rst_i && !upg_rst_q);
  assign forced_dbg = dbg_req_i && starve_at_max;

  // Port grant and memory steering for the current cycle.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = cpu_addr_i;
    mem_wdata_o = cpu_wdata_i;
    cpu_stall_o = 1'b0;
    dbg_ack_o   = 1'b0;
    cpu_gnt     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (forced_dbg) begin
          mem_en_o    = 1'b1;
          mem_addr_o  = dbg_addr_i;
          dbg_ack_o   = 1'b1;
          cpu_stall_o = cpu_req_i;
        end else if (cpu_req_i) begin
          mem_en_o = 1'b1;
          mem_we_o = cpu_we_i;
          cpu_gnt  = 1'b1;
        end else if (dbg_req_i) begin
          mem_en_o   = 1'b1;
          mem_addr_o = dbg_addr_i;
          dbg_ack_o  = 1'b1;
        end
      end
      PROG: begin
        // The programmer only ever writes, so no read tag is produced here.
        mem_en_o    = upg_we_i;
        mem_we_o    = upg_we_i;
        mem_addr_o  = upg_addr_i;
        mem_wdata_o = upg_wdata_i;
        cpu_stall_o = cpu_req_i;
      end
      DRAIN: begin
        // Idle port for one cycle so the final programmer write lands first.
        cpu_stall_o = cpu_req_i;
      end
      default: begin
        cpu_stall_o = cpu_req_i;
      end
    endcase
  end

  // Mode FSM, edge detect on upg_rst_i and read-response owner tag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= RUN;
      upg_rst_q   <= 1'b1;
      tag_q       <= OWN_NONE;
      prog_busy_o <= 1'b0;
    end else begin
      upg_rst_q <= upg_rst_i;
      if (mem_en_o && !mem_we_o) begin
        tag_q <= dbg_ack_o ? OWN_DBG : OWN_CPU;
      end else begin
        tag_q <= OWN_NONE;
      end
      unique case (state_q)
        RUN: begin
          if (enter_prog) begin
            state_q     <= PROG;
            prog_busy_o <= 1'b1;
          end
        end
        PROG: begin
          if (leave_prog) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          state_q     <= RUN;
          prog_busy_o <= 1'b0;
        end
        default: begin
          state_q     <= RUN;
          prog_busy_o <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_rvalid_o = (tag_q == OWN_CPU);
  assign dbg_rvalid_o = (tag_q == OWN_DBG);
  assign rdata_o      = mem_rdata_i;
  assign state_o      = state_q;

  // Debug wait counter: counts while a debug request is held unserved.
  dmem_arb_starve_ctr #(
    .W   (STARVE_W),
    .MAX (STARVE_LIM)
  ) u_starve (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (!dbg_req_i || dbg_ack_o),
    .inc    (dbg_req_i && !dbg_ack_o),
    .cnt    (starve_cnt_o),
    .at_max (starve_at_max)
  );

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] cpu_grants;
  logic [STAT_W-1:0] dbg_grants;
  logic [STAT_W-1:0] cpu_stalls;
  logic              cpu_grants_max;
  logic              dbg_grants_max;
  logic              cpu_stalls_max;

  // Arbitration-loss stalls only; stalls during programming are implied by
  // prog_busy_o and would swamp the count.
  dmem_arb_starve_ctr #(.W(STAT_W), .MAX('1)) u_cpu_grants (
    .clk(clk), .rstn(rstn), .clr(enter_prog),
    .inc(cpu_gnt && !cpu_grants_max), .cnt(cpu_grants), .at_max(cpu_grants_max)
  );
  dmem_arb_starve_ctr #(.W(STAT_W), .MAX('1)) u_dbg_grants (
    .clk(clk), .rstn(rstn), .clr(enter_prog),
    .inc(dbg_ack_o && !dbg_grants_max), .cnt(dbg_grants), .at_max(dbg_grants_max)
  );
  dmem_arb_starve_ctr #(.W(STAT_W), .MAX('1)) u_cpu_stalls (
    .clk(clk), .rstn(rstn), .clr(enter_prog),
    .inc(cpu_stall_o && (state_q == RUN) && !cpu_stalls_max),
    .cnt(cpu_stalls), .at_max(cpu_stalls_max)
  );

  assign stats_o = {cpu_stalls, dbg_grants, cpu_grants};
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a cycle reference model.
// Stats checks are included when DMEM_ARB_STATS_EN is defined.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 15;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic              upg_rst_i = 1'b1, upg_done_i = 1'b0, upg_we_i = 1'b0;
  logic [ADDR_W-1:0] upg_addr_i = '0;
  logic [DATA_W-1:0] upg_wdata_i = '0;
  logic              cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [ADDR_W-1:0] cpu_addr_i = '0;
  logic [DATA_W-1:0] cpu_wdata_i = '0;
  logic              dbg_req_i = 1'b0;
  logic [ADDR_W-1:0] dbg_addr_i = '0;
  logic              cpu_stall_o, dbg_ack_o, mem_en_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i, rdata_o;
  logic              cpu_rvalid_o, dbg_rvalid_o, prog_busy_o;
  logic [1:0]        state_o;
  logic [7:0]        starve_cnt_o;
`ifdef DMEM_ARB_STATS_EN
  logic [47:0]       stats_o;
`endif

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rstn(rstn),
    .upg_rst_i(upg_rst_i), .upg_done_i(upg_done_i), .upg_we_i(upg_we_i),
    .upg_addr_i(upg_addr_i), .upg_wdata_i(upg_wdata_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_stall_o(cpu_stall_o),
    .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_ack_o(dbg_ack_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .cpu_rvalid_o(cpu_rvalid_o), .dbg_rvalid_o(dbg_rvalid_o),
    .rdata_o(rdata_o), .prog_busy_o(prog_busy_o),
`ifdef DMEM_ARB_STATS_EN
    .stats_o(stats_o),
`endif
    .state_o(state_o), .starve_cnt_o(starve_cnt_o)
  );

  // ---------------- memory behind the port ----------------
  logic [31:0] mem [0:255];
  logic [31:0] rd_q = '0;
  logic        preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (mem_en_o) begin
      if (mem_we_o) mem[mem_addr_o[7:0]] <= mem_wdata_o;
      else          rd_q <= mem[mem_addr_o[7:0]];
    end
  end
  assign mem_rdata_i = rd_q;

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctl();
    return {mem_en_o, mem_we_o, cpu_stall_o, dbg_ack_o, cpu_rvalid_o, dbg_rvalid_o, prog_busy_o};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; preload = 1'b1;
    upg_rst_i = 1'b1; upg_done_i = 1'b0; upg_we_i = 1'b0;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; dbg_req_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    rstn = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0] upg;      // {upg_rst, upg_done, upg_we}
    logic [7:0] ua;
    logic [1:0] cpu;      // {cpu_req, cpu_we}
    logic [7:0] ca;
    logic       dreq;
    logic [6:0] exp;      // {en, we, stall, ack, crv, drv, busy}
    logic [7:0] ea;
    logic       rchk;
    logic [31:0] ed;
  } vec_t;

  function automatic vec_t v(logic [2:0] upg, logic [7:0] ua, logic [1:0] cpu,
                             logic [7:0] ca, logic dreq, logic [6:0] exp,
                             logic [7:0] ea, logic rchk, logic [31:0] ed);
    vec_t r;
    r.upg = upg; r.ua = ua; r.cpu = cpu; r.ca = ca; r.dreq = dreq;
    r.exp = exp; r.ea = ea; r.rchk = rchk; r.ed = ed;
    return r;
  endfunction

  vec_t tbl [24];

  // reference model state for the random phase
  logic [31:0] sh [0:255];
  logic [33:0] exp_q [$];
  int          m_mode, m_wait, sess_left, cpu_load;
  logic        m_last_upg, use_done;
  logic        e_en, e_we, e_stall, e_ack, e_crv, e_drv;
  logic [7:0]  e_addr;
  logic [31:0] e_wd, e_rd;
  logic [33:0] pend;

  initial begin
    // reset / idle, plain CPU read and response
    tbl[0]  = v(3'b100, 8'h00, 2'b00, 8'h00, 1'b0, 7'b0000000, 8'h00, 1'b0, 32'h0);
    tbl[1]  = v(3'b100, 8'h00, 2'b10, 8'h10, 1'b0, 7'b1000000, 8'h10, 1'b0, 32'h0);
    tbl[2]  = v(3'b100, 8'h00, 2'b00, 8'h00, 1'b0, 7'b0000100, 8'h00, 1'b1, 32'h1000_0010);
    // programming session: fall, three writes, done pulse, drain
    tbl[3]  = v(3'b000, 8'h00, 2'b00, 8'h00, 1'b0, 7'b0000000, 8'h00, 1'b0, 32'h0);
    tbl[4]  = v(3'b001, 8'h00, 2'b10, 8'h10, 1'b0, 7'b1110001, 8'h00, 1'b0, 32'h0);
    tbl[5]  = v(3'b001, 8'h01, 2'b00, 8'h00, 1'b0, 7'b1100001, 8'h01, 1'b0, 32'h0);
    tbl[6]  = v(3'b001, 8'h02, 2'b10, 8'h10, 1'b1, 7'b1110001, 8'h02, 1'b0, 32'h0);
    tbl[7]  = v(3'b010, 8'h00, 2'b10, 8'h10, 1'b0, 7'b0010001, 8'h00, 1'b0, 32'h0);
    tbl[8]  = v(3'b100, 8'h00, 2'b10, 8'h10, 1'b0, 7'b0010001, 8'h00, 1'b0, 32'h0);
    tbl[9]  = v(3'b100, 8'h00, 2'b10, 8'h01, 1'b0, 7'b1000000, 8'h01, 1'b0, 32'h0);
    tbl[10] = v(3'b100, 8'h00, 2'b00, 8'h00, 1'b0, 7'b0000100, 8'h00, 1'b1, 32'hA5A5_0001);
    // entry during a granted CPU read, exit by upg_rst rising
    tbl[11] = v(3'b000, 8'h00, 2'b10, 8'h10, 1'b0, 7'b1000000, 8'h10, 1'b0, 32'h0);
    tbl[12] = v(3'b000, 8'h00, 2'b10, 8'h10, 1'b0, 7'b0010101, 8'h00, 1'b1, 32'h1000_0010);
    tbl[13] = v(3'b100, 8'h00, 2'b00, 8'h00, 1'b0, 7'b0000001, 8'h00, 1'b0, 32'h0);
    tbl[14] = v(3'b100, 8'h00, 2'b00, 8'h00, 1'b0, 7'b0000001, 8'h00, 1'b0, 32'h0);
    tbl[15] = v(3'b100, 8'h00, 2'b00, 8'h00, 1'b0, 7'b0000000, 8'h00, 1'b0, 32'h0);
    // debug read, upg_we ignored in RUN, CPU write, CPU beats debug
    tbl[16] = v(3'b100, 8'h00, 2'b00, 8'h00, 1'b1, 7'b1001000, 8'h20, 1'b0, 32'h0);
    tbl[17] = v(3'b100, 8'h00, 2'b00, 8'h00, 1'b0, 7'b0000010, 8'h00, 1'b1, 32'h1000_0020);
    tbl[18] = v(3'b101, 8'h05, 2'b00, 8'h00, 1'b0, 7'b0000000, 8'h00, 1'b0, 32'h0);
    tbl[19] = v(3'b100, 8'h00, 2'b11, 8'h10, 1'b0, 7'b1100000, 8'h10, 1'b0, 32'h0);
    tbl[20] = v(3'b100, 8'h00, 2'b00, 8'h00, 1'b0, 7'b0000000, 8'h00, 1'b0, 32'h0);
    tbl[21] = v(3'b100, 8'h00, 2'b10, 8'h10, 1'b1, 7'b1000000, 8'h10, 1'b0, 32'h0);
    tbl[22] = v(3'b100, 8'h00, 2'b00, 8'h00, 1'b1, 7'b1001100, 8'h20, 1'b1, 32'hC0DE_0010);
    tbl[23] = v(3'b100, 8'h00, 2'b00, 8'h00, 1'b0, 7'b0000010, 8'h00, 1'b1, 32'h1000_0020);

    // reset state
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", 64'(ctl()), 64'h0);
    check("reset_state", 64'(state_o), 64'(RUN));
    check("reset_starve", 64'(starve_cnt_o), 64'h0);
    do_reset();

    for (int i = 0; i < 24; i++) begin
      {upg_rst_i, upg_done_i, upg_we_i} = tbl[i].upg;
      upg_addr_i  = 14'(tbl[i].ua);
      upg_wdata_i = 32'hA5A5_0000 + 32'(tbl[i].ua);
      {cpu_req_i, cpu_we_i} = tbl[i].cpu;
      cpu_addr_i  = 14'(tbl[i].ca);
      cpu_wdata_i = 32'hC0DE_0000 + 32'(tbl[i].ca);
      dbg_req_i   = tbl[i].dreq;
      dbg_addr_i  = 14'h20;
      @(negedge clk);
      check($sformatf("vec%0d_ctl", i), 64'(ctl()), 64'(tbl[i].exp));
      if (tbl[i].exp[6]) check($sformatf("vec%0d_addr", i), 64'(mem_addr_o), 64'(tbl[i].ea));
      if (tbl[i].exp[6] && tbl[i].exp[5])
        check($sformatf("vec%0d_wdata", i), 64'(mem_wdata_o),
              tbl[i].exp[0] ? 64'(32'hA5A5_0000 + 32'(tbl[i].ua))
                            : 64'(32'hC0DE_0000 + 32'(tbl[i].ca)));
      if (tbl[i].rchk) check($sformatf("vec%0d_rdata", i), 64'(rdata_o), 64'(tbl[i].ed));
      next_cycle();
    end

    // CPU held against a waiting debug request: forced grant on cycle 16
    upg_rst_i = 1'b1; upg_done_i = 1'b0; upg_we_i = 1'b0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 14'h10;
    dbg_req_i = 1'b1; dbg_addr_i = 14'h21;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c < 16) begin
        check($sformatf("starve_c%0d_ack_stall", c), 64'({dbg_ack_o, cpu_stall_o}), 64'h0);
      end else begin
        check("starve_forced_ack_stall", 64'({dbg_ack_o, cpu_stall_o}), 64'h3);
        check("starve_forced_addr", 64'(mem_addr_o), 64'h21);
        check("starve_cnt_at_limit", 64'(starve_cnt_o), 64'(STARVE_MAX));
      end
      next_cycle();
    end
    dbg_req_i = 1'b0;
    @(negedge clk);
    check("starve_dbg_rvalid", 64'({cpu_rvalid_o, dbg_rvalid_o, cpu_stall_o}), 64'h2);
    check("starve_rdata", 64'(rdata_o), 64'(32'h1000_0021));
    check("starve_cnt_cleared", 64'(starve_cnt_o), 64'h0);
    next_cycle();

    // async reset between grant and response
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 14'h10;
    @(negedge clk);
    check("arst_grant", 64'(mem_en_o), 64'h1);
    next_cycle();
    cpu_req_i = 1'b0;
    #1 rstn = 1'b0;
    #2 rstn = 1'b1;
    @(negedge clk);
    check("arst_no_rvalid", 64'({cpu_rvalid_o, dbg_rvalid_o, prog_busy_o}), 64'h0);
    check("arst_state", 64'(state_o), 64'(RUN));
    next_cycle();
    cpu_req_i = 1'b1; cpu_addr_i = 14'h11;
    next_cycle();
    cpu_req_i = 1'b0;
    @(negedge clk);
    check("arst_after_read", 64'({cpu_rvalid_o, rdata_o}), 64'({1'b1, 32'h1000_0011}));
    next_cycle();

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 256; i++) sh[i] = 32'h1000_0000 + 32'(i);
    exp_q.delete();
    m_mode = 0; m_wait = 0; m_last_upg = 1'b1; sess_left = 0; cpu_load = 5; use_done = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) cpu_load = $urandom_range(3, 10);
      if (sess_left > 0) begin
        upg_rst_i  = 1'b0;
        upg_we_i   = 1'($urandom_range(0, 1));
        upg_done_i = (sess_left == 1) && use_done;
        sess_left--;
      end else begin
        upg_rst_i  = 1'b1;
        upg_done_i = 1'b0;
        upg_we_i   = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 99) < 3) begin
          sess_left = $urandom_range(3, 12);
          use_done  = 1'($urandom_range(0, 1));
        end
      end
      upg_addr_i  = 14'($urandom_range(0, 255));
      upg_wdata_i = $urandom;
      cpu_req_i   = ($urandom_range(1, 10) <= cpu_load);
      cpu_we_i    = 1'($urandom_range(0, 1));
      cpu_addr_i  = 14'($urandom_range(0, 255));
      cpu_wdata_i = $urandom;
      if (!dbg_req_i) begin
        dbg_req_i  = ($urandom_range(0, 2) == 0);
        dbg_addr_i = 14'($urandom_range(0, 255));
      end

      // expected port behaviour for this cycle
      e_en = 1'b0; e_we = 1'b0; e_stall = 1'b0; e_ack = 1'b0;
      e_addr = '0; e_wd = '0;
      if (m_mode == 0) begin
        if (dbg_req_i && m_wait == STARVE_MAX) begin
          e_en = 1'b1; e_ack = 1'b1; e_addr = dbg_addr_i[7:0]; e_stall = cpu_req_i;
        end else if (cpu_req_i) begin
          e_en = 1'b1; e_we = cpu_we_i; e_addr = cpu_addr_i[7:0]; e_wd = cpu_wdata_i;
        end else if (dbg_req_i) begin
          e_en = 1'b1; e_ack = 1'b1; e_addr = dbg_addr_i[7:0];
        end
      end else if (m_mode == 1) begin
        e_en = upg_we_i; e_we = upg_we_i; e_addr = upg_addr_i[7:0]; e_wd = upg_wdata_i;
        e_stall = cpu_req_i;
      end else begin
        e_stall = cpu_req_i;
      end
      pend = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h0;
      e_crv = (pend[33:32] == 2'd1);
      e_drv = (pend[33:32] == 2'd2);
      e_rd  = pend[31:0];

      @(negedge clk);
      check("rand_ctl", 64'(ctl()),
            64'({e_en, e_we, e_stall, e_ack, e_crv, e_drv, (m_mode != 0)}));
      if (e_en) check("rand_addr", 64'(mem_addr_o), 64'(e_addr));
      if (e_en && e_we) check("rand_wdata", 64'(mem_wdata_o), 64'(e_wd));
      if (e_crv || e_drv) check("rand_rdata", 64'(rdata_o), 64'(e_rd));
      next_cycle();

      // advance the model
      if (e_en && !e_we) exp_q.push_back({e_ack ? 2'd2 : 2'd1, sh[e_addr]});
      if (e_en && e_we) sh[e_addr] = e_wd;
      if (dbg_req_i && !e_ack) m_wait = (m_wait < STARVE_MAX) ? m_wait + 1 : STARVE_MAX;
      else                     m_wait = 0;
      if (m_mode == 0)      m_mode = (m_last_upg && !upg_rst_i) ? 1 : 0;
      else if (m_mode == 1) m_mode = (upg_done_i || (upg_rst_i && !m_last_upg)) ? 2 : 1;
      else                  m_mode = 0;
      m_last_upg = upg_rst_i;
      if (e_ack) dbg_req_i = 1'b0;
    end

`ifdef DMEM_ARB_STATS_EN
    // 1 forced stall, 2 debug grants, 5 CPU grants after a programming session
    do_reset();
    upg_rst_i = 1'b0;
    next_cycle();
    dbg_req_i = 1'b1; dbg_addr_i = 14'h30;
    repeat (16) next_cycle();
    upg_rst_i = 1'b1;
    repeat (2) next_cycle();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0;
    @(negedge clk);
    check("stats_forced", 64'({dbg_ack_o, cpu_stall_o}), 64'h3);
    next_cycle();
    dbg_req_i = 1'b0;
    repeat (5) next_cycle();
    cpu_req_i = 1'b0; dbg_req_i = 1'b1;
    next_cycle();
    dbg_req_i = 1'b0;
    next_cycle();
    check("stats_value", 64'(stats_o), 64'({16'd1, 16'd2, 16'd5}));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
